cd_update_scheduler: RTL and testbench

Sequencer for the contrastive-divergence (CD) weight-update datapath of one DBN core. On a `start` pulse it captures the positive-phase (step 0) and reconstruction-phase (step 2) neuron states. It then walks every hidden-neuron row of the core's weight memory: read the row, drive the CD update unit, write the updated row back. The block sits between the core's sampling logic, the dual-port weight SRAM and the update unit, and sustains one row per cycle.

---
 rtl/cd_update_scheduler.sv | 124 ++++++++++++
 tb/tb_cd_update_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cd_update_scheduler.sv
// Row sequencer for the CD weight update: read row, drive update unit, write row back.
// Optional CD_SKIP_ZERO_ROW_EN suppresses SRAM/update traffic for rows with both hidden states 0.
module cd_update_scheduler #(
    parameter int unsigned NUM_HN = 16,
    parameter int unsigned NUM_VN = 16,
    parameter int unsigned ADDR_W = (NUM_HN > 1) ? $clog2(NUM_HN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_VN-1:0] v_states_0,
    input  logic [NUM_HN-1:0] h_states_0,
    input  logic [NUM_VN-1:0] v_states_2,
    input  logic [NUM_HN-1:0] h_states_2,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              upd_en,
    output logic [NUM_VN-1:0] upd_v0,
    output logic [NUM_VN-1:0] upd_v2,
    output logic              upd_h0,
    output logic              upd_h2
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rc_q, s2_row_q, s3_row_q;
    logic              s2_slot_q, s3_slot_q;
    logic              s2_en_q, s3_en_q;
    logic [NUM_VN-1:0] v0_q, v2_q;
    logic [NUM_HN-1:0] h0_q, h2_q;
    logic              rc_last;
    logic              row_active;

    assign rc_last = (rc_q == ADDR_W'(NUM_HN - 1));

`ifdef CD_SKIP_ZERO_ROW_EN
    // Both hidden states 0 means a zero delta on every lane, so the row is left untouched.
    assign row_active = h0_q[rc_q] | h2_q[rc_q];
`else
    assign row_active = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (rc_last) state_d = StDrain;
            // Slot valids track cycle slots, not enables, so skipped rows still drain in time.
            StDrain: if (!s2_slot_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_raddr = '0;
        unique case (state_q)
            StRun: begin
                busy      = 1'b1;
                mem_rd_en = row_active;
                mem_raddr = row_active ? rc_q : '0;
            end
            StDrain: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
        upd_en    = s2_en_q;
        upd_h0    = s2_en_q & h0_q[s2_row_q];
        upd_h2    = s2_en_q & h2_q[s2_row_q];
        upd_v0    = s2_en_q ? v0_q : '0;
        upd_v2    = s2_en_q ? v2_q : '0;
        mem_we    = s3_en_q;
        mem_waddr = s3_en_q ? s3_row_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q      <= '0;
            v0_q      <= '0;
            v2_q      <= '0;
            h0_q      <= '0;
            h2_q      <= '0;
            s2_slot_q <= 1'b0;
            s2_en_q   <= 1'b0;
            s2_row_q  <= '0;
            s3_slot_q <= 1'b0;
            s3_en_q   <= 1'b0;
            s3_row_q  <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                v0_q <= v_states_0;
                v2_q <= v_states_2;
                h0_q <= h_states_0;
                h2_q <= h_states_2;
                rc_q <= '0;
            end else if (state_q == StRun && !rc_last) begin
                rc_q <= rc_q + ADDR_W'(1);
            end
            s2_slot_q <= (state_q == StRun);
            s2_en_q   <= mem_rd_en;
            s2_row_q  <= rc_q;
            s3_slot_q <= s2_slot_q;
            s3_en_q   <= s2_en_q;
            s3_row_q  <= s2_row_q;
        end
    end

endmodule

// File: tb/tb_cd_update_scheduler.sv
// Directed bench for cd_update_scheduler: a 4-row instance and a 1-row instance share one clock.
module tb_cd_update_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-row instance
    logic       a_start = 1'b0;
    logic [3:0] a_v0 = '0, a_v2 = '0, a_h0 = '0, a_h2 = '0;
    logic       a_busy, a_done, a_rd_en, a_we, a_upd_en, a_uh0, a_uh2;
    logic [1:0] a_raddr, a_waddr;
    logic [3:0] a_uv0, a_uv2;

    cd_update_scheduler #(.NUM_HN(4), .NUM_VN(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start),
        .v_states_0(a_v0), .h_states_0(a_h0), .v_states_2(a_v2), .h_states_2(a_h2),
        .busy(a_busy), .done(a_done), .mem_rd_en(a_rd_en), .mem_raddr(a_raddr),
        .mem_we(a_we), .mem_waddr(a_waddr), .upd_en(a_upd_en),
        .upd_v0(a_uv0), .upd_v2(a_uv2), .upd_h0(a_uh0), .upd_h2(a_uh2)
    );

    // 1-row instance
    logic       b_start = 1'b0;
    logic [3:0] b_v0 = 4'h9, b_v2 = 4'h6;
    logic [0:0] b_h0 = 1'b1, b_h2 = 1'b1;
    logic       b_busy, b_done, b_rd_en, b_we, b_upd_en, b_uh0, b_uh2;
    logic [0:0] b_raddr, b_waddr;
    logic [3:0] b_uv0, b_uv2;

    cd_update_scheduler #(.NUM_HN(1), .NUM_VN(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start),
        .v_states_0(b_v0), .h_states_0(b_h0), .v_states_2(b_v2), .h_states_2(b_h2),
        .busy(b_busy), .done(b_done), .mem_rd_en(b_rd_en), .mem_raddr(b_raddr),
        .mem_we(b_we), .mem_waddr(b_waddr), .upd_en(b_upd_en),
        .upd_v0(b_uv0), .upd_v2(b_uv2), .upd_h0(b_uh0), .upd_h2(b_uh2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    function automatic bit act(input logic [3:0] h0, input logic [3:0] h2, input int r);
`ifdef CD_SKIP_ZERO_ROW_EN
        return h0[r] | h2[r];
`else
        return 1'b1;
`endif
    endfunction

    // Expected outputs of the 4-row instance in cycle c of a run started at E0.
    task automatic check_a(input int c, input logic [3:0] h0, input logic [3:0] h2,
                           input logic [3:0] v0, input logic [3:0] v2);
        bit rd, ue, we;
        int rr, ru, rw;
        rr = c - 1;
        ru = c - 2;
        rw = c - 3;
        rd = (c >= 1 && c <= 4) ? act(h0, h2, rr) : 1'b0;
        ue = (c >= 2 && c <= 5) ? act(h0, h2, ru) : 1'b0;
        we = (c >= 3 && c <= 6) ? act(h0, h2, rw) : 1'b0;
        chk("a_rd_en", c, 32'(a_rd_en), 32'(rd));
        chk("a_raddr", c, 32'(a_raddr), rd ? 32'(rr) : 32'd0);
        chk("a_upd_en", c, 32'(a_upd_en), 32'(ue));
        chk("a_upd_h0", c, 32'(a_uh0), ue ? 32'(h0[ru]) : 32'd0);
        chk("a_upd_h2", c, 32'(a_uh2), ue ? 32'(h2[ru]) : 32'd0);
        chk("a_upd_v0", c, 32'(a_uv0), ue ? 32'(v0) : 32'd0);
        chk("a_upd_v2", c, 32'(a_uv2), ue ? 32'(v2) : 32'd0);
        chk("a_we", c, 32'(a_we), 32'(we));
        chk("a_waddr", c, 32'(a_waddr), we ? 32'(rw) : 32'd0);
        chk("a_busy", c, 32'(a_busy), (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
        chk("a_done", c, 32'(a_done), (c == 7) ? 32'd1 : 32'd0);
    endtask

    // Full run with inputs scrambled after the start edge.
    task automatic run_a(input logic [3:0] h0, input logic [3:0] h2);
        logic [3:0] v0, v2;
        v0 = 4'hA ^ h0;
        v2 = 4'h5 ^ h2;
        a_h0 = h0;
        a_h2 = h2;
        a_v0 = v0;
        a_v2 = v2;
        a_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                a_start = 1'b0;
                a_h0 = ~h0;
                a_h2 = ~h2;
                a_v0 = ~v0;
                a_v2 = ~v2;
            end
            check_a(c, h0, h2, v0, v2);
        end
    endtask

    initial begin
        tick();
        tick();
        check_a(0, 4'hF, 4'hF, 4'h0, 4'h0);
        rst = 1'b0;
        tick();
        check_a(0, 4'hF, 4'hF, 4'h0, 4'h0);

        run_a(4'b1111, 4'b1111);
        run_a(4'b0101, 4'b0011);

        // start held high: nothing accepted until IDLE in cycle 8, next read in cycle 9
        a_h0 = 4'hF;
        a_h2 = 4'hF;
        a_v0 = 4'h3;
        a_v2 = 4'hC;
        a_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_a(c, 4'hF, 4'hF, 4'h3, 4'hC);
        end
        tick();
        chk("hold_rd_en", 9, 32'(a_rd_en), 32'd1);
        chk("hold_raddr", 9, 32'(a_raddr), 32'd0);
        chk("hold_busy", 9, 32'(a_busy), 32'd1);
        a_start = 1'b0;
        for (int c = 10; c <= 15; c++) tick();
        chk("hold_done", 15, 32'(a_done), 32'd1);
        tick();
        chk("hold_idle_busy", 16, 32'(a_busy), 32'd0);
        chk("hold_idle_done", 16, 32'(a_done), 32'd0);

        // reset asserted in cycle 3 aborts the run
        a_start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            a_start = 1'b0;
            check_a(c, 4'hF, 4'hF, 4'h3, 4'hC);
        end
        rst = 1'b1;
        tick();
        check_a(0, 4'hF, 4'hF, 4'h0, 4'h0);
        rst = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            tick();
            chk("rst_we", c, 32'(a_we), 32'd0);
            chk("rst_busy", c, 32'(a_busy), 32'd0);
            chk("rst_done", c, 32'(a_done), 32'd0);
        end
        run_a(4'b1111, 4'b1111);

        // single-row instance
        b_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            b_start = 1'b0;
            chk("b_rd_en", c, 32'(b_rd_en), (c == 1) ? 32'd1 : 32'd0);
            chk("b_upd_en", c, 32'(b_upd_en), (c == 2) ? 32'd1 : 32'd0);
            chk("b_upd_v0", c, 32'(b_uv0), (c == 2) ? 32'h9 : 32'd0);
            chk("b_upd_h2", c, 32'(b_uh2), (c == 2) ? 32'd1 : 32'd0);
            chk("b_we", c, 32'(b_we), (c == 3) ? 32'd1 : 32'd0);
            chk("b_waddr", c, 32'(b_waddr), 32'd0);
            chk("b_busy", c, 32'(b_busy), (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
            chk("b_done", c, 32'(b_done), (c == 4) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
